alu_serial_seq: RTL



---
 rtl/alu_serial_seq.sv | 113 +++++++++++
 1 files changed

// File: rtl/alu_serial_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_serial_seq
//  Brief    : Bit-serial AND/OR sequencer that feeds a 1-bit ALU slice LSB-first
//             and reassembles the returned F bits into a WIDTH-bit result.
//  Revision : 1.0  initial release
// ============================================================================
module alu_serial_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_sel,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_s,
    input  logic             slice_f,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [WIDTH-1:0]   a_sh_q,   a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,   b_sh_d;
    logic               sel_q,    sel_d;
    logic [WIDTH-1:0]   result_q, result_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sel_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sel_q    <= sel_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sel_d    = sel_q;
        result_d = result_q;
        slice_a  = 1'b0;
        slice_b  = 1'b0;
        slice_s  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d   = op_a;
                    b_sh_d   = op_b;
                    sel_d    = op_sel;
                    cnt_d    = '0;
                    result_d = '0;
                    state_d  = SHIFT;
                end
            end

            SHIFT: begin
                slice_a  = a_sh_q[0];
                slice_b  = b_sh_q[0];
                slice_s  = sel_q;
                // F arrives combinationally this cycle and enters at the MSB,
                // so after WIDTH edges bit 0 of the operands lands at bit 0.
                result_d = {slice_f, result_q[WIDTH-1:1]};
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign result = result_q;
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);

endmodule
`default_nettype wire
